// File: rtl/snake_head_ctrl.sv
// Snake head controller: steps the head across a fixed cell grid, detects apple eats,
// tracks snake length and ends the game when the head would leave the field.
module snake_head_ctrl #(
    parameter int unsigned CELL      = 10,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned TICK_DIV  = 5000000,
    parameter int unsigned START_X   = 320,
    parameter int unsigned START_Y   = 240,
    parameter int unsigned START_LEN = 3,
    parameter int unsigned MAX_LEN   = 63
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start_evt,
    input  logic [3:0] dir_btn,
    input  logic [9:0] apple_x,
    input  logic [8:0] apple_y,
    output logic [9:0] head_x,
    output logic [8:0] head_y,
    output logic       eat_evt,
    output logic [5:0] snake_len,
    output logic       running,
    output logic       game_over
);

    localparam int unsigned TickW = $clog2(TICK_DIV);

    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
    localparam logic [9:0]       CellX    = 10'(CELL);
    localparam logic [8:0]       CellY    = 9'(CELL);
    localparam logic [9:0]       MaxX     = 10'(H_RES - CELL);
    localparam logic [8:0]       MaxY     = 9'(V_RES - CELL);
    localparam logic [9:0]       StartX   = 10'(START_X);
    localparam logic [8:0]       StartY   = 9'(START_Y);
    localparam logic [5:0]       StartLen = 6'(START_LEN);
    localparam logic [5:0]       MaxLen   = 6'(MAX_LEN);

    // Direction is held one-hot in the same bit order as dir_btn: {up,down,left,right}.
    localparam logic [3:0] DirUp    = 4'b1000;
    localparam logic [3:0] DirDown  = 4'b0100;
    localparam logic [3:0] DirLeft  = 4'b0010;
    localparam logic [3:0] DirRight = 4'b0001;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDead
    } state_e;

    state_e           state_q, state_d;
    logic [9:0]       head_x_q, head_x_d;
    logic [8:0]       head_y_q, head_y_d;
    logic [5:0]       len_q, len_d;
    logic [3:0]       dir_q, dir_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic             eat_q, eat_d;
    logic             check_q, check_d;

    logic [3:0] dir_rev;
    logic       wall;
    logic [9:0] step_x;
    logic [8:0] step_y;

    assign dir_rev = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        len_d    = len_q;
        dir_d    = dir_q;
        tick_d   = tick_q;
        eat_d    = 1'b0;
        check_d  = 1'b0;
        wall     = 1'b0;
        step_x   = head_x_q;
        step_y   = head_y_q;

        case (state_q)
            StRun: begin
                // check_q marks the cycle right after a successful step.
                if (check_q && (head_x_q == apple_x) && (head_y_q == apple_y)) begin
                    eat_d = 1'b1;
                    if (len_q < MaxLen) begin
                        len_d = len_q + 6'd1;
                    end
                end

                if ($onehot(dir_btn) && (dir_btn != dir_rev)) begin
                    dir_d = dir_btn;
                end

                if (tick_q == TickLast) begin
                    tick_d = '0;
                    // Wall test is done on the current value so no wrap-around is relied on.
                    unique case (dir_d)
                        DirUp: begin
                            wall   = (head_y_q < CellY);
                            step_y = head_y_q - CellY;
                        end
                        DirDown: begin
                            wall   = (head_y_q >= MaxY);
                            step_y = head_y_q + CellY;
                        end
                        DirLeft: begin
                            wall   = (head_x_q < CellX);
                            step_x = head_x_q - CellX;
                        end
                        default: begin
                            wall   = (head_x_q >= MaxX);
                            step_x = head_x_q + CellX;
                        end
                    endcase

                    if (wall) begin
                        state_d = StDead;
                    end else begin
                        head_x_d = step_x;
                        head_y_d = step_y;
                        check_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end

            StIdle, StDead: begin
                if (start_evt) begin
                    state_d  = StRun;
                    head_x_d = StartX;
                    head_y_d = StartY;
                    len_d    = StartLen;
                    dir_d    = DirRight;
                    tick_d   = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            head_x_q <= StartX;
            head_y_q <= StartY;
            len_q    <= StartLen;
            dir_q    <= DirRight;
            tick_q   <= '0;
            eat_q    <= 1'b0;
            check_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            len_q    <= len_d;
            dir_q    <= dir_d;
            tick_q   <= tick_d;
            eat_q    <= eat_d;
            check_q  <= check_d;
        end
    end

    assign head_x    = head_x_q;
    assign head_y    = head_y_q;
    assign eat_evt   = eat_q;
    assign snake_len = len_q;
    assign running   = (state_q == StRun);
    assign game_over = (state_q == StDead);

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench for snake_head_ctrl: a fixed vector table for start/step/eat timing, then
// reference-model sequences for reversal, wall, saturation and reset corners.
module tb_snake_head_ctrl;

    localparam int TICK = 4;
    localparam logic [3:0] BUp    = 4'b1000;
    localparam logic [3:0] BDown  = 4'b0100;
    localparam logic [3:0] BLeft  = 4'b0010;
    localparam logic [3:0] BRight = 4'b0001;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start_evt;
    logic [3:0] dir_btn;
    logic [9:0] apple_x;
    logic [8:0] apple_y;
    logic [9:0] head_x;
    logic [8:0] head_y;
    logic       eat_evt;
    logic [5:0] snake_len;
    logic       running;
    logic       game_over;

    snake_head_ctrl #(.TICK_DIV(TICK)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_evt (start_evt),
        .dir_btn   (dir_btn),
        .apple_x   (apple_x),
        .apple_y   (apple_y),
        .head_x    (head_x),
        .head_y    (head_y),
        .eat_evt   (eat_evt),
        .snake_len (snake_len),
        .running   (running),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hx;
        int hy;
        bit eat;
        int len;
        bit run;
        bit go;
    } exp_t;

    typedef struct {
        bit   rn;
        bit   st;
        exp_t e;
    } vec_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   eat_seen = 0;
    int   ax_cur   = 0;
    int   ay_cur   = 0;

    // Reference model state: 0 idle, 1 run, 2 dead.
    int         m_state, m_x, m_y, m_len, m_tick;
    logic [3:0] m_dir;
    bit         m_eat, m_pend;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic score();
        exp_t e;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty at t=%0t", $time);
            return;
        end
        e = expq.pop_front();
        chk("head_x", int'(head_x), e.hx);
        chk("head_y", int'(head_y), e.hy);
        chk("eat_evt", int'(eat_evt), int'(e.eat));
        chk("snake_len", int'(snake_len), e.len);
        chk("running", int'(running), int'(e.run));
        chk("game_over", int'(game_over), int'(e.go));
        if (eat_evt === 1'b1) eat_seen++;
    endtask

    function automatic int dx_of(input logic [3:0] d);
        if (d == BRight) return 10;
        if (d == BLeft) return -10;
        return 0;
    endfunction

    function automatic int dy_of(input logic [3:0] d);
        if (d == BDown) return 10;
        if (d == BUp) return -10;
        return 0;
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            BUp:     return BDown;
            BDown:   return BUp;
            BLeft:   return BRight;
            default: return BLeft;
        endcase
    endfunction

    task automatic model(input bit rn, input bit st, input logic [3:0] db, input int ax,
                         input int ay);
        int nx, ny;
        if (!rn) begin
            m_state = 0; m_x = 320; m_y = 240; m_len = 3;
            m_dir = BRight; m_tick = 0; m_eat = 0; m_pend = 0;
            return;
        end
        m_eat = 0;
        if (m_state == 1) begin
            if (m_pend && m_x == ax && m_y == ay) begin
                m_eat = 1;
                m_len = (m_len + 1 > 63) ? 63 : m_len + 1;
            end
            m_pend = 0;
            if ($countones(db) == 1 && db != opposite(m_dir)) m_dir = db;
            if (m_tick == TICK - 1) begin
                m_tick = 0;
                nx = m_x + dx_of(m_dir);
                ny = m_y + dy_of(m_dir);
                if (nx < 0 || nx > 630 || ny < 0 || ny > 470) begin
                    m_state = 2;
                end else begin
                    m_x = nx; m_y = ny; m_pend = 1;
                end
            end else begin
                m_tick++;
            end
        end else begin
            m_pend = 0;
            if (st) begin
                m_state = 1; m_x = 320; m_y = 240; m_len = 3; m_dir = BRight; m_tick = 0;
            end
        end
    endtask

    // One clock: drive at the falling edge, score at the next falling edge.
    task automatic cyc(input bit rn, input bit st, input logic [3:0] db);
        reset_n   = rn;
        start_evt = st;
        dir_btn   = db;
        apple_x   = 10'(ax_cur);
        apple_y   = 9'(ay_cur);
        model(rn, st, db, ax_cur, ay_cur);
        expq.push_back('{hx: m_x, hy: m_y, eat: m_eat, len: m_len,
                         run: (m_state == 1), go: (m_state == 2)});
        @(posedge clk);
        @(negedge clk);
        score();
    endtask

    task automatic run(input int n, input logic [3:0] db);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, db);
    endtask

    // Request a direction for one cycle, then idle out the rest of a step period.
    task automatic press(input logic [3:0] db);
        cyc(1'b1, 1'b0, db);
        run(TICK - 1, 4'b0000);
    endtask

    task automatic restart(input int ax, input int ay);
        ax_cur = ax;
        ay_cur = ay;
        cyc(1'b0, 1'b0, 4'b0000);
        cyc(1'b1, 1'b1, 4'b0000);
    endtask

    function automatic vec_t mk(input bit rn, input bit st, input int hx, input int len,
                                input bit eat, input bit r);
        vec_t v;
        v.rn = rn;
        v.st = st;
        v.e  = '{hx: hx, hy: 240, eat: eat, len: len, run: r, go: 1'b0};
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[16];
        int         neat;
        int         guard;
        logic [3:0] nd;
        logic [3:0] pend_press;

        // Apple fixed at (340,240); start after two reset cycles, TICK_DIV=4.
        tbl[0]  = mk(0, 0, 320, 3, 0, 0);
        tbl[1]  = mk(0, 0, 320, 3, 0, 0);
        tbl[2]  = mk(1, 1, 320, 3, 0, 1);
        tbl[3]  = mk(1, 0, 320, 3, 0, 1);
        tbl[4]  = mk(1, 0, 320, 3, 0, 1);
        tbl[5]  = mk(1, 0, 320, 3, 0, 1);
        tbl[6]  = mk(1, 0, 330, 3, 0, 1);
        tbl[7]  = mk(1, 0, 330, 3, 0, 1);
        tbl[8]  = mk(1, 0, 330, 3, 0, 1);
        tbl[9]  = mk(1, 0, 330, 3, 0, 1);
        tbl[10] = mk(1, 0, 340, 3, 0, 1);
        tbl[11] = mk(1, 0, 340, 4, 1, 1);
        tbl[12] = mk(1, 0, 340, 4, 0, 1);
        tbl[13] = mk(1, 0, 340, 4, 0, 1);
        tbl[14] = mk(1, 0, 350, 4, 0, 1);
        tbl[15] = mk(1, 0, 350, 4, 0, 1);

        reset_n = 1'b0; start_evt = 1'b0; dir_btn = 4'b0000;
        apple_x = 10'd340; apple_y = 9'd240;
        for (int i = 0; i < 16; i++) begin
            reset_n   = tbl[i].rn;
            start_evt = tbl[i].st;
            expq.push_back(tbl[i].e);
            @(posedge clk);
            @(negedge clk);
            score();
        end

        // Reversal, multi-hot and start-in-run are ignored; up then left turns.
        restart(0, 0);
        run(8, BLeft);
        run(4, 4'b0011);
        cyc(1'b1, 1'b1, 4'b0000);
        run(3, 4'b0000);
        press(BUp);
        press(BLeft);
        run(2, 4'b0000);
        while (m_tick != TICK - 1) cyc(1'b1, 1'b0, 4'b0000);
        cyc(1'b1, 1'b0, BDown);
        chk("turn_in_step_cycle_y", int'(head_y), 240);
        run(4, 4'b0000);

        // Pass back over a stationary apple: one pulse per landing step only.
        restart(340, 240);
        eat_seen = 0;
        run(12, 4'b0000);
        press(BUp);
        press(BLeft);
        press(BDown);
        run(6, 4'b0000);
        chk("eat_count_revisit", eat_seen, 2);

        // Straight run into the right wall, then restart from DEAD.
        restart(0, 0);
        eat_seen = 0;
        run(130, 4'b0000);
        run(4, BUp);
        chk("wall_head_x", int'(head_x), 630);
        chk("wall_game_over", int'(game_over), 1);
        chk("wall_eats", eat_seen, 0);
        cyc(1'b1, 1'b1, 4'b0000);
        run(5, 4'b0000);

        // Length saturation: apple placed on the next head cell after every eat.
        restart(330, 240);
        eat_seen   = 0;
        neat       = 0;
        guard      = 0;
        pend_press = 4'b0000;
        while (neat < 62 && guard < 600) begin
            cyc(1'b1, 1'b0, pend_press);
            pend_press = 4'b0000;
            guard++;
            if (m_eat) begin
                neat++;
                nd = m_dir;
                if (m_dir == BRight && m_x >= 600) nd = BDown;
                else if (m_dir == BDown && m_y >= 400) nd = BLeft;
                else if (m_dir == BLeft && m_x <= 20) nd = BUp;
                else if (m_dir == BUp && m_y <= 20) nd = BRight;
                pend_press = nd;
                ax_cur = m_x + dx_of(nd);
                ay_cur = m_y + dy_of(nd);
            end
        end
        if (guard >= 600) begin
            n_checks++;
            n_fail++;
            $display("FAIL saturation_budget: only %0d eats within %0d cycles", neat, guard);
        end
        chk("sat_eat_pulses", eat_seen, 62);
        chk("sat_len", int'(snake_len), 63);

        // Reset on a step cycle that would land on the apple.
        restart(330, 240);
        run(3, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        run(5, 4'b0000);
        chk("reset_step_running", int'(running), 0);

        // Reset on the cycle that would raise eat_evt.
        restart(330, 240);
        run(4, 4'b0000);
        cyc(1'b0, 1'b0, 4'b0000);
        chk("reset_eat_cycle_eat", int'(eat_evt), 0);
        run(3, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
